// File: rtl/bp_fe_pkg.sv
// Shared types and constants for the front-end branch predictor blocks.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_bht_init,
    e_bht_ready,
    e_bht_upd_wr
  } bp_fe_bht_state_e;

  // Weakly-not-taken counter value {1'b0, {cnt_w-1{1'b1}}}, zero-extended to 32 bits.
  function automatic logic [31:0] bht_wnt_f(input int cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with a registered not-full ready and valid/yumi dequeue.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               full_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] els_lp  = cnt_w_lp'(els_p);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr, r_rptr;
  logic [cnt_w_lp-1:0] r_cnt;
  logic                r_ready;
  logic                w_enq, w_deq;
  logic [cnt_w_lp-1:0] w_cnt_n;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_lp) ? '0 : p + 1'b1;
  endfunction

  assign v_o     = (r_cnt != '0);
  assign full_o  = (r_cnt == els_lp);
  assign w_deq   = yumi_i & v_o;
  // A full queue may still accept when the head leaves in the same cycle.
  assign w_enq   = v_i & (~full_o | w_deq);
  assign data_o  = r_mem[r_rptr];
  assign ready_o = r_ready;

  always_comb begin
    w_cnt_n = r_cnt;
    if (w_enq && !w_deq) begin
      w_cnt_n = r_cnt + 1'b1;
    end else if (!w_enq && w_deq) begin
      w_cnt_n = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_enq) r_wptr <= ptr_inc(r_wptr);
      if (w_deq) r_rptr <= ptr_inc(r_rptr);
      r_cnt   <= w_cnt_n;
      r_ready <= (w_cnt_n != els_lp);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bp_fe_bht_ctrl.sv
// BHT port sequencer: table init, fetch prediction reads and queued
// read-modify-write counter updates sharing one 1RW RAM port.
module bp_fe_bht_ctrl
  import bp_fe_pkg::*;
#(
  parameter int bht_idx_width_p   = 3,
  parameter int bp_cnt_sat_bits_p = 2,
  parameter int upd_fifo_els_p    = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         r_v_i,
  input  logic [bht_idx_width_p-1:0]   r_idx_i,
  output logic                         r_ready_o,
  output logic                         predict_v_o,
  output logic                         predict_o,
  input  logic                         w_v_i,
  input  logic [bht_idx_width_p-1:0]   w_idx_i,
  input  logic                         w_taken_i,
  output logic                         w_ready_o,
  output logic                         init_done_o,
  output logic                         ram_v_o,
  output logic                         ram_w_o,
  output logic [bht_idx_width_p-1:0]   ram_addr_o,
  output logic [bp_cnt_sat_bits_p-1:0] ram_data_o,
  input  logic [bp_cnt_sat_bits_p-1:0] ram_data_i
);

  localparam int cnt_w_lp   = bp_cnt_sat_bits_p;
  localparam int entry_w_lp = bht_idx_width_p + 1;
  localparam logic [31:0]         wnt32_lp = bht_wnt_f(cnt_w_lp);
  localparam logic [cnt_w_lp-1:0] wnt_lp   = wnt32_lp[cnt_w_lp-1:0];

  bp_fe_bht_state_e            r_state, w_state_n;
  logic [bht_idx_width_p-1:0]  r_init_ptr;
  logic                        r_init_done;
  logic                        r_pred_v;

  logic                        w_fifo_ready, w_fifo_v, w_fifo_full, w_fifo_yumi;
  logic                        w_push;
  logic [entry_w_lp-1:0]       w_fifo_data;
  logic [bht_idx_width_p-1:0]  w_head_idx;
  logic                        w_head_taken;

  logic                        w_ram_v, w_ram_w, w_r_ready, w_pop;
  logic [bht_idx_width_p-1:0]  w_ram_addr;
  logic [cnt_w_lp-1:0]         w_ram_data;

  function automatic logic [cnt_w_lp-1:0] sat_step(input logic [cnt_w_lp-1:0] c,
                                                   input logic                taken);
    if (taken) return (&c) ? c : c + 1'b1;
    else       return (|c) ? c - 1'b1 : c;
  endfunction

  assign w_push       = w_v_i & w_ready_o;
  assign w_head_idx   = w_fifo_data[entry_w_lp-1:1];
  assign w_head_taken = w_fifo_data[0];

  bsg_fifo_1r1w_small #(
    .width_p (entry_w_lp),
    .els_p   (upd_fifo_els_p)
  ) upd_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (w_push),
    .ready_o (w_fifo_ready),
    .data_i  ({w_idx_i, w_taken_i}),
    .v_o     (w_fifo_v),
    .data_o  (w_fifo_data),
    .yumi_i  (w_fifo_yumi),
    .full_o  (w_fifo_full)
  );

  always_comb begin
    w_state_n  = r_state;
    w_ram_v    = 1'b0;
    w_ram_w    = 1'b0;
    w_ram_addr = r_init_ptr;
    w_ram_data = wnt_lp;
    w_r_ready  = 1'b0;
    w_pop      = 1'b0;
    case (r_state)
      e_bht_init: begin
        w_ram_v = 1'b1;
        w_ram_w = 1'b1;
        if (r_init_ptr == '1) w_state_n = e_bht_ready;
      end
      e_bht_ready: begin
        // Updates yield to reads unless the queue is full, which bounds their wait.
        if (w_fifo_v && (w_fifo_full || !r_v_i)) begin
          w_ram_v    = 1'b1;
          w_ram_addr = w_head_idx;
          w_state_n  = e_bht_upd_wr;
        end else if (r_v_i) begin
          w_r_ready  = 1'b1;
          w_ram_v    = 1'b1;
          w_ram_addr = r_idx_i;
        end
      end
      e_bht_upd_wr: begin
        w_ram_v    = 1'b1;
        w_ram_w    = 1'b1;
        w_ram_addr = w_head_idx;
        w_ram_data = sat_step(ram_data_i, w_head_taken);
        w_pop      = 1'b1;
        w_state_n  = e_bht_ready;
      end
      default: w_state_n = e_bht_init;
    endcase
  end

  // Reset masks the RAM port and read handshake in the same cycle, so an
  // in-flight update write is dropped rather than committed.
  assign ram_v_o     = w_ram_v & ~reset_i;
  assign ram_w_o     = w_ram_w;
  assign ram_addr_o  = w_ram_addr;
  assign ram_data_o  = w_ram_data;
  assign r_ready_o   = w_r_ready & ~reset_i;
  assign w_fifo_yumi = w_pop & ~reset_i;
  assign w_ready_o   = w_fifo_ready & r_init_done;
  assign init_done_o = r_init_done;
  assign predict_v_o = r_pred_v;
  assign predict_o   = r_pred_v & ram_data_i[cnt_w_lp-1];

  // Stage p0 -> p1: RAM read data returns alongside the delayed accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= e_bht_init;
      r_init_ptr  <= '0;
      r_init_done <= 1'b0;
      r_pred_v    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_pred_v <= r_v_i & r_ready_o;
      if (r_state == e_bht_init) begin
        r_init_ptr <= r_init_ptr + 1'b1;
        if (r_init_ptr == '1) r_init_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// Scoreboard bench for bp_fe_bht_ctrl with a fake 1RW RAM and a counter-array model.
module tb_bp_fe_bht_ctrl;

  localparam int IW  = 3;
  localparam int CW  = 2;
  localparam int ELS = 8;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          r_v_i = 1'b0;
  logic [IW-1:0] r_idx_i = '0;
  logic          r_ready_o, predict_v_o, predict_o;
  logic          w_v_i = 1'b0;
  logic [IW-1:0] w_idx_i = '0;
  logic          w_taken_i = 1'b0;
  logic          w_ready_o, init_done_o;
  logic          ram_v_o, ram_w_o;
  logic [IW-1:0] ram_addr_o;
  logic [CW-1:0] ram_data_o;
  logic [CW-1:0] rdata = '0;

  always #5 clk = ~clk;

  bp_fe_bht_ctrl #(
    .bht_idx_width_p   (IW),
    .bp_cnt_sat_bits_p (CW),
    .upd_fifo_els_p    (2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .r_v_i       (r_v_i),
    .r_idx_i     (r_idx_i),
    .r_ready_o   (r_ready_o),
    .predict_v_o (predict_v_o),
    .predict_o   (predict_o),
    .w_v_i       (w_v_i),
    .w_idx_i     (w_idx_i),
    .w_taken_i   (w_taken_i),
    .w_ready_o   (w_ready_o),
    .init_done_o (init_done_o),
    .ram_v_o     (ram_v_o),
    .ram_w_o     (ram_w_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_data_i  (rdata)
  );

  // Fake 1RW RAM, pre-filled with a value INIT must overwrite.
  logic [CW-1:0] mem [ELS];
  initial for (int i = 0; i < ELS; i++) mem[i] = 2'b10;
  always @(posedge clk) begin
    if (ram_v_o) begin
      if (ram_w_o) mem[ram_addr_o] <= ram_data_o;
      else         rdata <= mem[ram_addr_o];
    end
  end

  int checks = 0;
  int errors = 0;
  int model [ELS];
  int exp_q [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every prediction the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (predict_v_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL predict_unexpected: got %0d expected none", predict_o);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("predict", int'(predict_o), e);
      end
    end
  end

  task automatic step(input logic rv, input int ridx, input logic wv, input int widx,
                      input logic wt, output logic racc, output logic wacc);
    @(negedge clk);
    r_v_i = rv; r_idx_i = IW'(ridx);
    w_v_i = wv; w_idx_i = IW'(widx); w_taken_i = wt;
    #1;
    racc = rv & r_ready_o;
    wacc = wv & w_ready_o;
    if (racc) exp_q.push_back((model[ridx] >= (1 << (CW - 1))) ? 1 : 0);
    if (wacc) begin
      if (wt) model[widx] = (model[widx] < (1 << CW) - 1) ? model[widx] + 1 : model[widx];
      else    model[widx] = (model[widx] > 0) ? model[widx] - 1 : 0;
    end
  endtask

  task automatic idle(input int n);
    logic ra, wa;
    repeat (n) step(1'b0, 0, 1'b0, 0, 1'b0, ra, wa);
  endtask

  task automatic do_read(input int idx);
    logic ra, wa;
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b1, idx, 1'b0, 0, 1'b0, ra, wa);
      ok = ra;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL read_timeout: got no accept expected accept for idx %0d", idx);
    end
  endtask

  task automatic do_upd(input int idx, input logic t);
    logic ra, wa;
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b0, 0, 1'b1, idx, t, ra, wa);
      ok = wa;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL upd_timeout: got no accept expected accept for idx %0d", idx);
    end
  endtask

  task automatic mem_compare(input string nm);
    for (int i = 0; i < ELS; i++) chk(nm, int'(mem[i]), model[i]);
  endtask

  task automatic init_seq();
    @(negedge clk);
    reset_i = 1'b1; r_v_i = 1'b0; w_v_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_r_ready", int'(r_ready_o), 0);
    chk("rst_w_ready", int'(w_ready_o), 0);
    chk("rst_predict_v", int'(predict_v_o), 0);
    chk("rst_predict", int'(predict_o), 0);
    chk("rst_init_done", int'(init_done_o), 0);
    chk("rst_ram_v", int'(ram_v_o), 0);
    @(negedge clk);
    reset_i = 1'b0; r_v_i = 1'b1; w_v_i = 1'b1; w_idx_i = 3'd3;
    #1;
    for (int k = 0; k < ELS; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk("init_write", int'(ram_v_o & ram_w_o), 1);
      chk("init_addr", int'(ram_addr_o), k);
      chk("init_data", int'(ram_data_o), 1);
      chk("init_done_early", int'(init_done_o), 0);
      chk("init_r_ready", int'(r_ready_o), 0);
      chk("init_w_ready", int'(w_ready_o), 0);
    end
    @(negedge clk);
    r_v_i = 1'b0; w_v_i = 1'b0;
    #1;
    chk("init_done_rise", int'(init_done_o), 1);
    chk("post_init_w_ready", int'(w_ready_o), 1);
    chk("post_init_idle", int'(ram_v_o), 0);
    for (int i = 0; i < ELS; i++) model[i] = 1;
    exp_q.delete();
  endtask

  initial begin
    logic ra, wa;
    int pat [7] = '{1, 1, 0, 0, 1, 1, 1};
    int bp;
    bit found;
    int acc;

    init_seq();
    mem_compare("init_mem");

    // Taken updates saturate at the top.
    do_read(5);
    repeat (3) do_upd(5, 1'b1);
    idle(8);
    chk("sat_hi_mem", int'(mem[5]), 3);
    do_read(5);

    // Not-taken updates saturate at zero.
    repeat (3) do_upd(2, 1'b0);
    idle(8);
    chk("sat_lo_mem", int'(mem[2]), 0);
    do_read(2);

    // Continuous reads: updates wait until the queue is full.
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 6, (c < 2), c, 1'b1, ra, wa);
      chk("arb_r_ready", int'(ra), pat[c]);
      if (c < 2) chk("arb_w_accept", int'(wa), 1);
    end
    idle(8);
    mem_compare("arb_mem");

    // Held update stream: backpressure appears, nothing is lost.
    bp = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 0, 1'b1, int'($urandom_range(0, ELS - 1)), 1'($urandom_range(0, 1)), ra, wa);
      if (!w_ready_o) bp++;
    end
    chk("backpressure_seen", int'(bp > 0), 1);
    idle(8);
    mem_compare("stream_mem");

    // Random mix: reads target the half of the table not being updated this round.
    for (int r = 0; r < 16; r++) begin
      int abase, bbase;
      abase = (r % 2) * 4;
      bbase = 4 - abase;
      for (int c = 0; c < 30; c++) begin
        step(1'($urandom_range(0, 1)), bbase + int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), abase + int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ra, wa);
      end
      idle(8);
    end
    mem_compare("random_mem");

    // Reset landing on the update write cycle.
    step(1'b0, 0, 1'b1, 4, 1'b1, ra, wa);
    chk("rmw_push", int'(wa), 1);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      r_v_i = 1'b0; w_v_i = 1'b0;
      #1;
      if (ram_v_o && ram_w_o) begin
        found = 1'b1;
        reset_i = 1'b1;
        #1;
        chk("rst_mid_rmw_no_write", int'(ram_v_o), 0);
      end
    end
    chk("upd_wr_reached", int'(found), 1);
    init_seq();
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (ram_v_o) acc++;
    end
    chk("queue_flushed", acc, 0);
    do_read(4);
    idle(3);
    mem_compare("final_mem");
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
